// File: rtl/ddr_test_status.sv
// Verdict stage behind the DDR traffic checkers: calibration resync, sticky error flags and counters,
// test FSM, status LED and throughput test point. Define STALL_MON_EN to add the app_rdy stall watchdog.
module ddr_test_status #(
  parameter int SETTLE_CYCLES = 256,
  parameter int ERR_CNT_W     = 16,
  parameter int BLINK_SLOW_W  = 24,
  parameter int BLINK_FAST_W  = 21
`ifdef STALL_MON_EN
  , parameter int STALL_LIMIT = 4096
`endif
) (
  input  logic                 memory_clk,
  input  logic                 rst_n,
  input  logic                 init_calib_complete,
  input  logic                 error_int1,
  input  logic                 error_int2,
  input  logic                 app_rdy,
  input  logic                 err_clr,
  output logic                 init_calib_complete_d,
  output logic                 error,
  output logic                 error1,
  output logic                 led,
  output logic                 test_pt,
  output logic [1:0]           state_o,
  output logic [ERR_CNT_W-1:0] err_cnt1,
  output logic [ERR_CNT_W-1:0] err_cnt2
`ifdef STALL_MON_EN
  , output logic               stall
`endif
);

  localparam int SC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [1:0] {
    ST_WAIT_CAL = 2'd0,
    ST_SETTLE   = 2'd1,
    ST_RUN      = 2'd2,
    ST_FAIL     = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic                  sync1_q, sync2_q;
  logic [SC_W-1:0]       settle_cnt_q, settle_cnt_d;
  logic                  error_q, error_d;
  logic                  error1_q, error1_d;
  logic [ERR_CNT_W-1:0]  err_cnt1_q, err_cnt1_d;
  logic [ERR_CNT_W-1:0]  err_cnt2_q, err_cnt2_d;
  logic [BLINK_SLOW_W-1:0] blink_q, blink_d;
  logic                  test_pt_q, test_pt_d;
  logic                  err_live;
  logic                  stall_hit;

`ifdef STALL_MON_EN
  localparam int SL_W = (STALL_LIMIT > 1) ? $clog2(STALL_LIMIT) : 1;
  logic [SL_W-1:0] stall_cnt_q, stall_cnt_d;
  logic            stall_q, stall_d;

  assign stall_hit = (state_q == ST_RUN) && !app_rdy && (stall_cnt_q == SL_W'(STALL_LIMIT - 1));

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    stall_d     = stall_q;
    if (err_clr) begin
      stall_cnt_d = '0;
      stall_d     = 1'b0;
    end else if (state_q != ST_RUN || app_rdy) begin
      stall_cnt_d = '0;
    end else if (stall_hit) begin
      stall_d     = 1'b1;
      stall_cnt_d = '0;
    end else begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge memory_clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      stall_q     <= 1'b0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      stall_q     <= stall_d;
    end
  end

  assign stall = stall_q;
`else
  assign stall_hit = 1'b0;
`endif

  // Verdict FSM; err_clr overrides every other transition.
  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    case (state_q)
      ST_WAIT_CAL: begin
        if (sync2_q) begin
          state_d      = ST_SETTLE;
          settle_cnt_d = '0;
        end
      end
      ST_SETTLE: begin
        settle_cnt_d = settle_cnt_q + 1'b1;
        if (!sync2_q) begin
          state_d = ST_WAIT_CAL;
        end else if (settle_cnt_q == SC_W'(SETTLE_CYCLES - 1)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (error_int1 || error_int2 || !sync2_q || stall_hit) begin
          state_d = ST_FAIL;
        end
      end
      ST_FAIL: state_d = ST_FAIL;
      default: state_d = ST_WAIT_CAL;
    endcase
    if (err_clr) begin
      state_d = ST_WAIT_CAL;
    end
  end

  assign err_live = (state_q == ST_RUN) || (state_q == ST_FAIL);

  always_comb begin
    error_d    = error_q;
    error1_d   = error1_q;
    err_cnt1_d = err_cnt1_q;
    err_cnt2_d = err_cnt2_q;
    if (err_clr) begin
      error_d    = 1'b0;
      error1_d   = 1'b0;
      err_cnt1_d = '0;
      err_cnt2_d = '0;
    end else if (err_live) begin
      if (error_int1) begin
        error_d = 1'b1;
        if (err_cnt1_q != {ERR_CNT_W{1'b1}}) err_cnt1_d = err_cnt1_q + 1'b1;
      end
      if (error_int2) begin
        error1_d = 1'b1;
        if (err_cnt2_q != {ERR_CNT_W{1'b1}}) err_cnt2_d = err_cnt2_q + 1'b1;
      end
    end
  end

  always_comb begin
    blink_d   = blink_q + 1'b1;
    test_pt_d = test_pt_q ^ (app_rdy && err_live);
  end

  always_ff @(posedge memory_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      state_q      <= ST_WAIT_CAL;
      settle_cnt_q <= '0;
      error_q      <= 1'b0;
      error1_q     <= 1'b0;
      err_cnt1_q   <= '0;
      err_cnt2_q   <= '0;
      blink_q      <= '0;
      test_pt_q    <= 1'b0;
    end else begin
      sync1_q      <= init_calib_complete;
      sync2_q      <= sync1_q;
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      error_q      <= error_d;
      error1_q     <= error1_d;
      err_cnt1_q   <= err_cnt1_d;
      err_cnt2_q   <= err_cnt2_d;
      blink_q      <= blink_d;
      test_pt_q    <= test_pt_d;
    end
  end

  always_comb begin
    led = 1'b0;
    case (state_q)
      ST_WAIT_CAL: led = 1'b0;
      ST_SETTLE:   led = 1'b1;
      ST_RUN:      led = blink_q[BLINK_SLOW_W-1];
      ST_FAIL:     led = blink_q[BLINK_FAST_W-1];
      default:     led = 1'b0;
    endcase
  end

  assign init_calib_complete_d = sync2_q;
  assign error                 = error_q;
  assign error1                = error1_q;
  assign err_cnt1              = err_cnt1_q;
  assign err_cnt2              = err_cnt2_q;
  assign test_pt               = test_pt_q;
  assign state_o               = state_q;

endmodule

// File: tb/tb_ddr_test_status.sv
// Self-checking bench for ddr_test_status: expectations are queued when stimulus is driven
// and popped when the DUT output is sampled (#1 after the rising edge).
module tb_ddr_test_status;
  localparam int W = 15;

  logic memory_clk = 1'b0;
  logic rst_n = 1'b1;
  logic init_calib_complete = 1'b0;
  logic error_int1 = 1'b0;
  logic error_int2 = 1'b0;
  logic app_rdy = 1'b0;
  logic err_clr = 1'b0;
  logic init_calib_complete_d, error, error1, led, test_pt;
  logic [1:0] state_o;
  logic [3:0] err_cnt1, err_cnt2;
`ifdef STALL_MON_EN
  logic stall;
`endif

  ddr_test_status #(
    .SETTLE_CYCLES(256),
    .ERR_CNT_W(4),
    .BLINK_SLOW_W(6),
    .BLINK_FAST_W(4)
`ifdef STALL_MON_EN
    , .STALL_LIMIT(16)
`endif
  ) dut (
    .memory_clk(memory_clk),
    .rst_n(rst_n),
    .init_calib_complete(init_calib_complete),
    .error_int1(error_int1),
    .error_int2(error_int2),
    .app_rdy(app_rdy),
    .err_clr(err_clr),
    .init_calib_complete_d(init_calib_complete_d),
    .error(error),
    .error1(error1),
    .led(led),
    .test_pt(test_pt),
    .state_o(state_o),
    .err_cnt1(err_cnt1),
    .err_cnt2(err_cnt2)
`ifdef STALL_MON_EN
    , .stall(stall)
`endif
  );

  logic [W-1:0] exp_q[$];
  logic [W-1:0] got, want;
  int n_checks = 0;
  int n_pass = 0;
  int tb_cyc;
  logic exp_tp = 1'b0;

  // clock / reset block
  always #5 memory_clk = ~memory_clk;

  // Edges seen since reset release; the DUT blink counter must equal this.
  always @(posedge memory_clk or negedge rst_n) begin
    if (!rst_n) tb_cyc <= 0;
    else        tb_cyc <= tb_cyc + 1;
  end

  wire [W-1:0] obs = {state_o, error, error1, err_cnt1, err_cnt2, init_calib_complete_d, led, test_pt};

  function automatic logic [W-1:0] vec(input logic [1:0] st, input logic e, input logic e1,
                                       input logic [3:0] c1, input logic [3:0] c2,
                                       input logic icd, input logic ld, input logic tp);
    return {st, e, e1, c1, c2, icd, ld, tp};
  endfunction

  // Expected LED k edges from now.
  function automatic logic led_for(input logic [1:0] st, input int k);
    int v;
    v = tb_cyc + k;
    case (st)
      2'd0:    return 1'b0;
      2'd1:    return 1'b1;
      2'd2:    return v[5];
      default: return v[3];
    endcase
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge memory_clk);
      #1;
    end
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    for (int i = 0; i < 100; i++) begin
      exp_q.push_back(vec(2'd0, 0, 0, 4'd0, 4'd0, 0, 0, 0));
      cyc(1);
      got = obs; want = exp_q.pop_front(); n_checks++;
      if (got === want) n_pass++; else $display("FAIL reset got=%h want=%h", got, want);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_calib();
    init_calib_complete = 1'b1;
    exp_q.push_back(vec(2'd0, 0, 0, 4'd0, 4'd0, 0, 0, 0));
    cyc(1);
    got = obs; want = exp_q.pop_front(); n_checks++;
    if (got === want) n_pass++; else $display("FAIL sync_lat1 got=%h want=%h", got, want);
    exp_q.push_back(vec(2'd0, 0, 0, 4'd0, 4'd0, 1, 0, 0));
    cyc(1);
    got = obs; want = exp_q.pop_front(); n_checks++;
    if (got === want) n_pass++; else $display("FAIL sync_lat2 got=%h want=%h", got, want);
    exp_q.push_back(vec(2'd1, 0, 0, 4'd0, 4'd0, 1, 1, 0));
    cyc(1);
    got = obs; want = exp_q.pop_front(); n_checks++;
    if (got === want) n_pass++; else $display("FAIL settle_entry got=%h want=%h", got, want);
    cyc(100);
    error_int1 = 1'b1; error_int2 = 1'b1;
    cyc(1);
    error_int1 = 1'b0; error_int2 = 1'b0;
    exp_q.push_back(vec(2'd1, 0, 0, 4'd0, 4'd0, 1, 1, 0));
    cyc(154);
    got = obs; want = exp_q.pop_front(); n_checks++;
    if (got === want) n_pass++; else $display("FAIL settle_end got=%h want=%h", got, want);
    exp_q.push_back(vec(2'd2, 0, 0, 4'd0, 4'd0, 1, led_for(2'd2, 1), 0));
    cyc(1);
    got = obs; want = exp_q.pop_front(); n_checks++;
    if (got === want) n_pass++; else $display("FAIL run_entry got=%h want=%h", got, want);
  endtask

  task automatic test_run_error();
    for (int i = 0; i < 6; i++) begin
      app_rdy = 1'($urandom_range(0, 1));
      if (app_rdy) exp_tp = ~exp_tp;
      exp_q.push_back(vec(2'd2, 0, 0, 4'd0, 4'd0, 1, led_for(2'd2, 1), exp_tp));
      cyc(1);
      got = obs; want = exp_q.pop_front(); n_checks++;
      if (got === want) n_pass++; else $display("FAIL run_tp got=%h want=%h", got, want);
    end
    app_rdy = 1'b0;
    error_int1 = 1'b1;
    exp_q.push_back(vec(2'd3, 1, 0, 4'd1, 4'd0, 1, led_for(2'd3, 1), exp_tp));
    cyc(1);
    error_int1 = 1'b0;
    got = obs; want = exp_q.pop_front(); n_checks++;
    if (got === want) n_pass++; else $display("FAIL err1_pulse got=%h want=%h", got, want);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(vec(2'd3, 1, 0, 4'd1, 4'd0, 1, led_for(2'd3, 3), exp_tp));
      cyc(3);
      got = obs; want = exp_q.pop_front(); n_checks++;
      if (got === want) n_pass++; else $display("FAIL fail_led got=%h want=%h", got, want);
    end
  endtask

  task automatic test_fail_test_pt();
    for (int i = 0; i < 30; i++) begin
      app_rdy = 1'($urandom_range(0, 1));
      if (app_rdy) exp_tp = ~exp_tp;
      exp_q.push_back(vec(2'd3, 1, 0, 4'd1, 4'd0, 1, led_for(2'd3, 1), exp_tp));
      cyc(1);
      got = obs; want = exp_q.pop_front(); n_checks++;
      if (got === want) n_pass++; else $display("FAIL fail_tp got=%h want=%h", got, want);
    end
    app_rdy = 1'b0;
  endtask

  task automatic test_clr_priority();
    err_clr = 1'b1; error_int1 = 1'b1;
    exp_q.push_back(vec(2'd0, 0, 0, 4'd0, 4'd0, 1, 0, exp_tp));
    cyc(1);
    err_clr = 1'b0; error_int1 = 1'b0;
    got = obs; want = exp_q.pop_front(); n_checks++;
    if (got === want) n_pass++; else $display("FAIL clr_prio got=%h want=%h", got, want);
    exp_q.push_back(vec(2'd1, 0, 0, 4'd0, 4'd0, 1, 1, exp_tp));
    cyc(1);
    got = obs; want = exp_q.pop_front(); n_checks++;
    if (got === want) n_pass++; else $display("FAIL clr_resettle got=%h want=%h", got, want);
    cyc(255);
    exp_q.push_back(vec(2'd2, 0, 0, 4'd0, 4'd0, 1, led_for(2'd2, 1), exp_tp));
    cyc(1);
    got = obs; want = exp_q.pop_front(); n_checks++;
    if (got === want) n_pass++; else $display("FAIL rerun got=%h want=%h", got, want);
  endtask

  task automatic test_saturate();
    error_int2 = 1'b1;
    for (int i = 0; i < 40; i++) begin
      exp_q.push_back(vec(2'd3, 0, 1, 4'd0, (i + 1 > 15) ? 4'd15 : 4'(i + 1), 1,
                          led_for(2'd3, 1), exp_tp));
      cyc(1);
      got = obs; want = exp_q.pop_front(); n_checks++;
      if (got === want) n_pass++; else $display("FAIL sat got=%h want=%h", got, want);
    end
    error_int2 = 1'b0;
    exp_q.push_back(vec(2'd3, 0, 1, 4'd0, 4'd15, 1, led_for(2'd3, 1), exp_tp));
    cyc(1);
    got = obs; want = exp_q.pop_front(); n_checks++;
    if (got === want) n_pass++; else $display("FAIL sat_hold got=%h want=%h", got, want);
  endtask

  task automatic test_reset_mid();
    rst_n = 1'b0;
    exp_tp = 1'b0;
    exp_q.push_back(vec(2'd0, 0, 0, 4'd0, 4'd0, 0, 0, 0));
    #1;
    got = obs; want = exp_q.pop_front(); n_checks++;
    if (got === want) n_pass++; else $display("FAIL async_reset got=%h want=%h", got, want);
    cyc(2);
    rst_n = 1'b1;
    cyc(258);
    exp_q.push_back(vec(2'd2, 0, 0, 4'd0, 4'd0, 1, led_for(2'd2, 1), 0));
    cyc(1);
    got = obs; want = exp_q.pop_front(); n_checks++;
    if (got === want) n_pass++; else $display("FAIL post_reset_run got=%h want=%h", got, want);
  endtask

  task automatic test_cal_loss();
    init_calib_complete = 1'b0;
    exp_q.push_back(vec(2'd2, 0, 0, 4'd0, 4'd0, 1, led_for(2'd2, 1), exp_tp));
    cyc(1);
    got = obs; want = exp_q.pop_front(); n_checks++;
    if (got === want) n_pass++; else $display("FAIL loss_d1 got=%h want=%h", got, want);
    exp_q.push_back(vec(2'd2, 0, 0, 4'd0, 4'd0, 0, led_for(2'd2, 1), exp_tp));
    cyc(1);
    got = obs; want = exp_q.pop_front(); n_checks++;
    if (got === want) n_pass++; else $display("FAIL loss_d2 got=%h want=%h", got, want);
    exp_q.push_back(vec(2'd3, 0, 0, 4'd0, 4'd0, 0, led_for(2'd3, 1), exp_tp));
    cyc(1);
    got = obs; want = exp_q.pop_front(); n_checks++;
    if (got === want) n_pass++; else $display("FAIL loss_fail got=%h want=%h", got, want);
    err_clr = 1'b1;
    exp_q.push_back(vec(2'd0, 0, 0, 4'd0, 4'd0, 0, 0, exp_tp));
    cyc(1);
    err_clr = 1'b0;
    got = obs; want = exp_q.pop_front(); n_checks++;
    if (got === want) n_pass++; else $display("FAIL clr_wait got=%h want=%h", got, want);
    app_rdy = 1'b1;
    exp_q.push_back(vec(2'd0, 0, 0, 4'd0, 4'd0, 0, 0, exp_tp));
    cyc(2);
    app_rdy = 1'b0;
    got = obs; want = exp_q.pop_front(); n_checks++;
    if (got === want) n_pass++; else $display("FAIL wait_tp_hold got=%h want=%h", got, want);
    init_calib_complete = 1'b1;
    exp_q.push_back(vec(2'd1, 0, 0, 4'd0, 4'd0, 1, 1, exp_tp));
    cyc(3);
    got = obs; want = exp_q.pop_front(); n_checks++;
    if (got === want) n_pass++; else $display("FAIL settle_again got=%h want=%h", got, want);
    cyc(20);
    init_calib_complete = 1'b0;
    exp_q.push_back(vec(2'd1, 0, 0, 4'd0, 4'd0, 0, 1, exp_tp));
    cyc(2);
    got = obs; want = exp_q.pop_front(); n_checks++;
    if (got === want) n_pass++; else $display("FAIL settle_loss_d got=%h want=%h", got, want);
    exp_q.push_back(vec(2'd0, 0, 0, 4'd0, 4'd0, 0, 0, exp_tp));
    cyc(1);
    got = obs; want = exp_q.pop_front(); n_checks++;
    if (got === want) n_pass++; else $display("FAIL settle_loss got=%h want=%h", got, want);
  endtask

`ifdef STALL_MON_EN
  task automatic test_stall();
    init_calib_complete = 1'b1;
    cyc(258);
    exp_q.push_back(vec(2'd2, 0, 0, 4'd0, 4'd0, 1, led_for(2'd2, 1), exp_tp));
    cyc(1);
    got = obs; want = exp_q.pop_front(); n_checks++;
    if (got === want) n_pass++; else $display("FAIL stall_run got=%h want=%h", got, want);
    exp_q.push_back(vec(2'd2, 0, 0, 4'd0, 4'd0, 1, led_for(2'd2, 15), exp_tp));
    cyc(15);
    got = obs; want = exp_q.pop_front(); n_checks++;
    if (got === want) n_pass++; else $display("FAIL stall_low15 got=%h want=%h", got, want);
    app_rdy = 1'b1;
    exp_tp = ~exp_tp;
    exp_q.push_back(vec(2'd2, 0, 0, 4'd0, 4'd0, 1, led_for(2'd2, 1), exp_tp));
    cyc(1);
    app_rdy = 1'b0;
    got = obs; want = exp_q.pop_front(); n_checks++;
    if (got === want) n_pass++; else $display("FAIL stall_rdy got=%h want=%h", got, want);
    exp_q.push_back(W'(0));
    got = W'(stall); want = exp_q.pop_front(); n_checks++;
    if (got === want) n_pass++; else $display("FAIL stall_clear got=%h want=%h", got, want);
    exp_q.push_back(vec(2'd2, 0, 0, 4'd0, 4'd0, 1, led_for(2'd2, 15), exp_tp));
    cyc(15);
    got = obs; want = exp_q.pop_front(); n_checks++;
    if (got === want) n_pass++; else $display("FAIL stall_again15 got=%h want=%h", got, want);
    exp_q.push_back(vec(2'd3, 0, 0, 4'd0, 4'd0, 1, led_for(2'd3, 1), exp_tp));
    cyc(1);
    got = obs; want = exp_q.pop_front(); n_checks++;
    if (got === want) n_pass++; else $display("FAIL stall_fire got=%h want=%h", got, want);
    exp_q.push_back(W'(1));
    got = W'(stall); want = exp_q.pop_front(); n_checks++;
    if (got === want) n_pass++; else $display("FAIL stall_flag got=%h want=%h", got, want);
  endtask
`endif

  initial begin
    test_reset();
    test_calib();
    test_run_error();
    test_fail_test_pt();
    test_clr_priority();
    test_saturate();
    test_reset_mid();
    test_cal_loss();
`ifdef STALL_MON_EN
    test_stall();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
